// File: rtl/multi_cycle_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_cycle_cpu                                              |
// | Description : Multi-cycle MIPS-subset CPU. One FSM sequences FETCH, DECODE, |
// |               EXEC, MEM and WB over a shared datapath. Instruction and data |
// |               memories sit outside behind req/ack handshakes.              |
// |               Optional macro CPU_PERF_CNT_EN adds cycle and retired-       |
// |               instruction counters (cyc_cnt_o, ret_cnt_o).                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multi_cycle_cpu #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PERF_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [31:0]       imem_rdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [31:0]       dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [31:0]       dmem_rdata_i,
   output logic              halt_o,
`ifdef CPU_PERF_CNT_EN
   output logic [PERF_W-1:0] cyc_cnt_o,
   output logic [PERF_W-1:0] ret_cnt_o,
`endif
   output logic [ADDR_W-1:0] pc_o
);

   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_J     = 6'h02;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_BNE   = 6'h05;
   localparam logic [5:0] c_OP_ADDI  = 6'h08;
   localparam logic [5:0] c_OP_SLTI  = 6'h0A;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;
   localparam logic [5:0] c_FN_ADD   = 6'h20;
   localparam logic [5:0] c_FN_SUB   = 6'h22;
   localparam logic [5:0] c_FN_AND   = 6'h24;
   localparam logic [5:0] c_FN_OR    = 6'h25;
   localparam logic [5:0] c_FN_SLT   = 6'h2A;
   // Bits of the PC replaced by a jump target (low 28 bits)
   localparam logic [ADDR_W-1:0] c_JMASK = ADDR_W'(28'hFFF_FFFF);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q, bt_q, dmem_addr_q;
   logic [31:0]       ir_q, a_q, b_q, imm_q, alu_q, mdr_q, dmem_wdata_q;
   logic              imem_req_q, dmem_req_q, dmem_we_q, halt_q;
   logic [31:0]       rf_q [32];

   logic [5:0]        op, funct;
   logic [4:0]        rs, rt, rd, wb_dest;
   logic [31:0]       imm_sx, alu_d, wb_data;
   logic [ADDR_W-1:0] pc_inc_d, bt_d, jump_d;
   logic              dec_ok;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_sx   = {{16{ir_q[15]}}, ir_q[15:0]};
   assign pc_inc_d = pc_q + ADDR_W'(4);
   assign bt_d     = pc_q + ADDR_W'($signed({imm_sx[29:0], 2'b00}));
   assign jump_d   = (pc_q & ~c_JMASK) | ADDR_W'({ir_q[25:0], 2'b00});
   assign wb_dest  = (op == c_OP_RTYPE) ? rd : rt;
   assign wb_data  = (op == c_OP_LW) ? mdr_q : alu_q;

   // Opcode/funct legality check, evaluated while in DECODE
   always_comb begin
      dec_ok = 1'b0;
      case (op)
         c_OP_RTYPE: begin
            case (funct)
               c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: dec_ok = 1'b1;
               default:                                          dec_ok = 1'b0;
            endcase
         end
         c_OP_ADDI, c_OP_SLTI, c_OP_BEQ, c_OP_BNE,
         c_OP_LW, c_OP_SW, c_OP_J:                               dec_ok = 1'b1;
         default:                                                dec_ok = 1'b0;
      endcase
   end

   // ALU: R-type ops, immediate ops and load/store address generation
   always_comb begin
      alu_d = '0;
      case (op)
         c_OP_RTYPE: begin
            case (funct)
               c_FN_ADD: alu_d = a_q + b_q;
               c_FN_SUB: alu_d = a_q - b_q;
               c_FN_AND: alu_d = a_q & b_q;
               c_FN_OR:  alu_d = a_q | b_q;
               c_FN_SLT: alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
               default:  alu_d = '0;
            endcase
         end
         c_OP_ADDI, c_OP_LW, c_OP_SW: alu_d = a_q + imm_q;
         c_OP_SLTI:                   alu_d = {31'b0, $signed(a_q) < $signed(imm_q)};
         default:                     alu_d = '0;
      endcase
   end

   // Control FSM with datapath registers, register file and registered bus outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         imm_q        <= '0;
         bt_q         <= '0;
         alu_q        <= '0;
         mdr_q        <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         halt_q       <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               // After reset the request rises one cycle late, so a stale ack is ignored
               if (!imem_req_q) begin
                  imem_req_q <= 1'b1;
               end else if (imem_ack_i) begin
                  imem_req_q <= 1'b0;
                  ir_q       <= imem_rdata_i;
                  pc_q       <= pc_inc_d;
                  state_q    <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q   <= rf_q[rs];
               b_q   <= rf_q[rt];
               imm_q <= imm_sx;
               bt_q  <= bt_d;
               if (dec_ok) begin
                  state_q <= S_EXEC;
               end else begin
                  state_q <= S_HALT;
                  halt_q  <= 1'b1;
               end
            end
            S_EXEC: begin
               alu_q <= alu_d;
               case (op)
                  c_OP_BEQ, c_OP_BNE: begin
                     if ((a_q == b_q) == (op == c_OP_BEQ)) pc_q <= bt_q;
                     imem_req_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end
                  c_OP_J: begin
                     pc_q       <= jump_d;
                     imem_req_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end
                  c_OP_LW, c_OP_SW: begin
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= (op == c_OP_SW);
                     dmem_addr_q  <= ADDR_W'(alu_d);
                     dmem_wdata_q <= b_q;
                     state_q      <= S_MEM;
                  end
                  default: state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               if (dmem_ack_i) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  mdr_q      <= dmem_rdata_i;
                  if (op == c_OP_SW) begin
                     imem_req_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end else begin
                     state_q <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_dest != 5'd0) rf_q[wb_dest] <= wb_data;
               imem_req_q <= 1'b1;
               state_q    <= S_FETCH;
            end
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_HALT;
         endcase
      end
   end

   assign imem_req_o   = imem_req_q;
   assign imem_addr_o  = pc_q;
   assign dmem_req_o   = dmem_req_q;
   assign dmem_we_o    = dmem_we_q;
   assign dmem_addr_o  = dmem_addr_q;
   assign dmem_wdata_o = dmem_wdata_q;
   assign halt_o       = halt_q;
   assign pc_o         = pc_q;

`ifdef CPU_PERF_CNT_EN
   logic [PERF_W-1:0] cyc_cnt_q, ret_cnt_q;
   logic              retire;

   assign retire = ((state_q == S_EXEC) &&
                    ((op == c_OP_BEQ) || (op == c_OP_BNE) || (op == c_OP_J))) ||
                   ((state_q == S_MEM) && dmem_ack_i && (op == c_OP_SW)) ||
                   (state_q == S_WB);

   // Free-running live-cycle and retired-instruction counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         if (state_q != S_HALT) cyc_cnt_q <= cyc_cnt_q + 1'b1;
         if (retire)            ret_cnt_q <= ret_cnt_q + 1'b1;
      end
   end

   assign cyc_cnt_o = cyc_cnt_q;
   assign ret_cnt_o = ret_cnt_q;
`endif

endmodule
`default_nettype wire
